// File: rtl/mtm_alu_deserializer.sv
// Receive side of the mtm_Alu serial link: rebuilds B, A and OP from 11-bit frames
// and validates frame count, CRC-4 and opcode before handing operands to the ALU core.
module mtm_alu_deserializer (
    input  logic        clk,
    input  logic        rst,
    input  logic        sin,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic [2:0]  op,
    output logic        valid,
    output logic        err_data,
    output logic        err_crc,
    output logic        err_op
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TYPE    = 2'd1,
        PAYLOAD = 2'd2,
        STOP    = 2'd3
    } state_t;

    state_t      state_q;
    logic        type_q;
    logic [2:0]  bit_cnt_q;
    logic [3:0]  data_cnt_q;
    logic [7:0]  byte_sr_q;
    logic [63:0] asm_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [2:0]  op_q;
    logic        valid_q;
    logic        err_data_q;
    logic        err_crc_q;
    logic        err_op_q;

    logic [2:0]  cmd_op_d;
    logic [3:0]  crc_d;
    logic        op_ok_d;

    // CRC-4, x^4+x+1, init 0, MSB first over the 68-bit message.
    function automatic logic [3:0] crc4(input logic [67:0] msg);
        logic [3:0] c;
        c = 4'h0;
        for (int i = 67; i >= 0; i--) begin
            c = {c[2:0], 1'b0} ^ ({4{c[3] ^ msg[i]}} & 4'h3);
        end
        return c;
    endfunction

    always_comb begin
        cmd_op_d = byte_sr_q[6:4];
        crc_d    = crc4({asm_q, 1'b1, cmd_op_d});
        op_ok_d  = (cmd_op_d == 3'b000) || (cmd_op_d == 3'b001) ||
                   (cmd_op_d == 3'b100) || (cmd_op_d == 3'b101);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            type_q     <= 1'b0;
            bit_cnt_q  <= 3'd0;
            data_cnt_q <= 4'd0;
            byte_sr_q  <= 8'd0;
            asm_q      <= 64'd0;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            op_q       <= 3'd0;
            valid_q    <= 1'b0;
            err_data_q <= 1'b0;
            err_crc_q  <= 1'b0;
            err_op_q   <= 1'b0;
        end else begin
            valid_q    <= 1'b0;
            err_data_q <= 1'b0;
            err_crc_q  <= 1'b0;
            err_op_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!sin) state_q <= TYPE;
                end
                TYPE: begin
                    type_q    <= sin;
                    bit_cnt_q <= 3'd0;
                    state_q   <= PAYLOAD;
                end
                PAYLOAD: begin
                    byte_sr_q <= {byte_sr_q[6:0], sin};
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_q <= STOP;
                end
                STOP: begin
                    state_q <= IDLE;
                    if (!sin) begin
                        err_data_q <= 1'b1;
                        data_cnt_q <= 4'd0;
                    end else if (!type_q) begin
                        // Count saturates at 9 so any overflow is remembered until the CMD frame.
                        if (data_cnt_q < 4'd8) begin
                            asm_q      <= {asm_q[55:0], byte_sr_q};
                            data_cnt_q <= data_cnt_q + 4'd1;
                        end else begin
                            data_cnt_q <= 4'd9;
                        end
                    end else begin
                        data_cnt_q <= 4'd0;
                        if (data_cnt_q != 4'd8) begin
                            err_data_q <= 1'b1;
                        end else if (crc_d != byte_sr_q[3:0]) begin
                            err_crc_q <= 1'b1;
                        end else if (!op_ok_d) begin
                            err_op_q <= 1'b1;
                        end else begin
                            b_q     <= asm_q[63:32];
                            a_q     <= asm_q[31:0];
                            op_q    <= cmd_op_d;
                            valid_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign a        = a_q;
    assign b        = b_q;
    assign op       = op_q;
    assign valid    = valid_q;
    assign err_data = err_data_q;
    assign err_crc  = err_crc_q;
    assign err_op   = err_op_q;

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// Randomised frame-level bench for mtm_alu_deserializer: a packet-level model pushes
// expected pulses into a queue, and a monitor pops them when the DUT pulses.
module tb_mtm_alu_deserializer;

    localparam int K_VALID = 0;
    localparam int K_DATA  = 1;
    localparam int K_CRC   = 2;
    localparam int K_OP    = 3;

    typedef struct {
        int          kind;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        sin;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        valid;
    logic        err_data;
    logic        err_crc;
    logic        err_op;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t exp_q[$];

    logic [7:0]  m_bytes[$];
    logic        m_ovf;
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic [2:0]  m_op;

    mtm_alu_deserializer dut (
        .clk      (clk),
        .rst      (rst),
        .sin      (sin),
        .a        (a),
        .b        (b),
        .op       (op),
        .valid    (valid),
        .err_data (err_data),
        .err_crc  (err_crc),
        .err_op   (err_op)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Remainder of {msg, 0000} divided by x^4+x+1 (polynomial long division).
    function automatic logic [3:0] crc_ref(input logic [31:0] bb, input logic [31:0] aa,
                                           input logic [2:0] oo);
        logic [71:0] r;
        r = {bb, aa, 1'b1, oo, 4'b0000};
        for (int i = 71; i >= 4; i--) begin
            if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
        end
        return r[3:0];
    endfunction

    function automatic void model_clear();
        m_bytes.delete();
        m_ovf = 1'b0;
    endfunction

    function automatic void push_exp(input int kind, input int c);
        exp_t e;
        e.kind = kind;
        e.a    = m_a;
        e.b    = m_b;
        e.op   = m_op;
        e.cyc  = c;
        exp_q.push_back(e);
    endfunction

    function automatic void model_frame(input logic typ, input logic [7:0] d, input logic stop,
                                        input int c);
        logic [31:0] pb;
        logic [31:0] pa;
        logic [2:0]  po;
        if (!stop) begin
            model_clear();
            push_exp(K_DATA, c);
        end else if (!typ) begin
            if (m_bytes.size() < 8) m_bytes.push_back(d);
            else m_ovf = 1'b1;
        end else begin
            if (m_ovf || m_bytes.size() != 8) begin
                push_exp(K_DATA, c);
            end else begin
                pb = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
                pa = {m_bytes[4], m_bytes[5], m_bytes[6], m_bytes[7]};
                po = d[6:4];
                if (crc_ref(pb, pa, po) != d[3:0]) begin
                    push_exp(K_CRC, c);
                end else if (!(po inside {3'b000, 3'b001, 3'b100, 3'b101})) begin
                    push_exp(K_OP, c);
                end else begin
                    m_a  = pa;
                    m_b  = pb;
                    m_op = po;
                    push_exp(K_VALID, c);
                end
            end
            model_clear();
        end
    endfunction

    // ---------------- drivers ----------------
    task automatic drive_bit(input logic v);
        @(negedge clk);
        sin = v;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_bit(1'b1);
    endtask

    task automatic send_frame(input logic typ, input logic [7:0] d, input logic stop);
        drive_bit(1'b0);
        drive_bit(typ);
        for (int i = 7; i >= 0; i--) drive_bit(d[i]);
        drive_bit(stop);
        model_frame(typ, d, stop, cyc + 1);
    endtask

    task automatic send_packet(input logic [31:0] pb, input logic [31:0] pa, input logic [2:0] po,
                               input logic [3:0] crc_xor, input int ndata, input int bad_stop,
                               input int gap);
        logic [63:0] ba;
        logic [7:0]  d;
        logic [3:0]  crc;
        ba = {pb, pa};
        for (int i = 0; i < ndata; i++) begin
            d = (i < 8) ? ba[63 - 8*i -: 8] : 8'($urandom);
            send_frame(1'b0, d, (i != bad_stop));
            if (i == bad_stop) begin
                idle(2);
                return;
            end
            idle(gap);
        end
        crc = crc_ref(pb, pa, po) ^ crc_xor;
        send_frame(1'b1, {1'b0, po, crc}, 1'b1);
        idle(gap);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        sin = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_clear();
        m_a  = 32'd0;
        m_b  = 32'd0;
        m_op = 3'd0;
        chk("reset_a", {32'd0, a}, {32'd0, m_a});
        chk("reset_b", {32'd0, b}, {32'd0, m_b});
        chk("reset_op", {61'd0, op}, {61'd0, m_op});
    endtask

    // ---------------- monitor / scoreboard ----------------
    int   n_pulse;
    int   got_kind;
    exp_t e;
    always @(negedge clk) begin
        if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_pulse exp_kind=%0d exp_cyc=%0d now=%0d", exp_q[0].kind,
                     exp_q[0].cyc, cyc);
            void'(exp_q.pop_front());
        end
        n_pulse = int'(valid) + int'(err_data) + int'(err_crc) + int'(err_op);
        if (n_pulse > 1) begin
            checks++;
            errors++;
            $display("FAIL multi_pulse v=%b ed=%b ec=%b eo=%b", valid, err_data, err_crc, err_op);
        end
        if (n_pulse > 0) begin
            got_kind = valid ? K_VALID : err_data ? K_DATA : err_crc ? K_CRC : K_OP;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse kind=%0d cyc=%0d", got_kind, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_kind", 64'(got_kind), 64'(e.kind));
                chk("pulse_cycle", 64'(cyc), 64'(e.cyc));
                chk("out_a", {32'd0, a}, {32'd0, e.a});
                chk("out_b", {32'd0, b}, {32'd0, e.b});
                chk("out_op", {61'd0, op}, {61'd0, e.op});
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst  = 1'b0;
        sin  = 1'b1;
        m_a  = 32'd0;
        m_b  = 32'd0;
        m_op = 3'd0;
        model_clear();
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Idle line: nothing happens, outputs stay at reset values.
        idle(50);
        chk("idle_a", {32'd0, a}, 64'd0);
        chk("idle_b", {32'd0, b}, 64'd0);
        chk("idle_op", {61'd0, op}, 64'd0);
        chk("idle_valid", {63'd0, valid}, 64'd0);
        chk("idle_err_data", {63'd0, err_data}, 64'd0);
        chk("idle_err_crc", {63'd0, err_crc}, 64'd0);
        chk("idle_err_op", {63'd0, err_op}, 64'd0);

        // Good ADD packet, with and without gaps.
        send_packet(32'h2, 32'h3, 3'b100, 4'h0, 8, -1, 2);
        send_packet(32'h2, 32'h3, 3'b100, 4'h0, 8, -1, 0);
        // CRC bit 0 flipped.
        send_packet(32'h2, 32'h3, 3'b100, 4'h1, 8, -1, 1);
        // Wrong data-frame counts, each followed by a good packet.
        send_packet(32'h11223344, 32'h55667788, 3'b001, 4'h0, 7, -1, 1);
        send_packet(32'h11223344, 32'h55667788, 3'b001, 4'h0, 8, -1, 1);
        send_packet(32'hdeadbeef, 32'h01234567, 3'b000, 4'h0, 9, -1, 0);
        send_packet(32'hdeadbeef, 32'h01234567, 3'b000, 4'h0, 8, -1, 0);
        // Unsupported opcode, then bad CRC plus bad opcode.
        send_packet(32'hcafe0001, 32'h0000ffff, 3'b010, 4'h0, 8, -1, 1);
        send_packet(32'hcafe0001, 32'h0000ffff, 3'b010, 4'h8, 8, -1, 1);
        // Stop bit low in the 3rd DATA frame, then a good SUB packet.
        send_packet(32'h12345678, 32'h9abcdef0, 3'b101, 4'h0, 8, 2, 0);
        send_packet(32'h80000000, 32'hffffffff, 3'b101, 4'h0, 8, -1, 0);

        // Reset in the middle of the 5th DATA frame.
        for (int i = 0; i < 4; i++) send_frame(1'b0, 8'($urandom), 1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        do_reset();
        idle(15);
        send_packet(32'h00000007, 32'h00000009, 3'b001, 4'h0, 8, -1, 0);

        // Random packets: random operands/opcodes, occasional bad CRC or frame count.
        for (int p = 0; p < 40; p++) begin
            logic [3:0] cx;
            int nd;
            int bad;
            cx  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            nd  = ($urandom_range(0, 5) == 0) ? $urandom_range(6, 10) : 8;
            bad = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 5) : -1;
            send_packet($urandom, $urandom, 3'($urandom_range(0, 7)), cx, nd, bad,
                        $urandom_range(0, 2));
        end

        idle(20);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
